// File: rtl/qnigma_tx_sched.sv
// -----------------------------------------------------------------------------
// qnigma_tx_sched
//
// Transmit scheduler between the protocol engines (ICMP, TCP, DNS, ...) and the
// single shared packet transmitter. One pending requester is picked, receives a
// one-cycle accept, and the transmitter gets a one-cycle send pulse. The owner
// index stays on o_sel for the whole frame and after it, so the metadata mux
// stays stable. A tick_ms based watchdog releases the transmitter slot if a
// frame never completes.
//
// Arbitration: round-robin starting at the pointer. With PRIO0=1, requester 0
// wins whenever it is pending.
//
// Optional feature (macro QNIGMA_TX_SCHED_STATS_EN):
//   defined   : o_stat_grants holds per-requester grant counts (16 bits each)
//               and o_stat_tmo holds the timeout count. Both saturate at 0xFFFF.
//   undefined : both ports exist and are tied to zero.
//
// Ports:
//   i_clk          system clock
//   i_rst          synchronous active-high reset
//   i_tick_ms      one-cycle pulse every millisecond
//   i_tx_pend[N]   per-requester frame-ready level, held until accepted
//   o_tx_acpt[N]   one-hot, one-cycle accept to the granted requester
//   o_tx_done[N]   transmitter tx_done routed to the current owner only
//   o_send         one-cycle start pulse to the transmitter
//   o_sel          index of the current/last owner
//   i_tx_busy      transmitter busy
//   i_tx_done      transmitter frame-complete pulse
//   o_tmo          one-cycle pulse on watchdog expiry
//   o_stat_grants  N x 16 grant counters (requester i at bits [16*i +: 16])
//   o_stat_tmo     16-bit timeout counter
// -----------------------------------------------------------------------------
module qnigma_tx_sched #(
    parameter int  N     = 3,
    parameter bit  PRIO0 = 1'b1,
    parameter int  TO_MS = 10,
    localparam int SW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_tick_ms,
    input  logic [N-1:0]    i_tx_pend,
    output logic [N-1:0]    o_tx_acpt,
    output logic [N-1:0]    o_tx_done,
    output logic            o_send,
    output logic [SW-1:0]   o_sel,
    input  logic            i_tx_busy,
    input  logic            i_tx_done,
    output logic            o_tmo,
    output logic [N*16-1:0] o_stat_grants,
    output logic [15:0]     o_stat_tmo
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    state_t        r_state;
    logic [SW-1:0] r_ptr;
    logic [7:0]    r_wd;

    logic [SW-1:0] w_win;
    logic          w_found;
    logic          w_grant;
    logic          w_expire;
    logic          w_tmo_evt;
    logic [7:0]    w_wd_inc;
    logic [SW-1:0] w_next_ptr;

    // Winner selection: optional strict priority for slot 0, otherwise the
    // first pending requester at or after the pointer, wrapping modulo N.
    always_comb begin
        int idx;
        // NOTE: every variable gets a default before any branch, so no latch is inferred.
        idx     = 0;
        w_win   = r_ptr;
        w_found = 1'b0;
        if (PRIO0 && i_tx_pend[0]) begin
            w_win   = '0;
            w_found = 1'b1;
        end else begin
            for (int i = 0; i < N; i++) begin
                idx = int'(r_ptr) + i;
                if (idx >= N) idx = idx - N;
                if (!w_found && i_tx_pend[idx]) begin
                    w_win   = SW'(idx);
                    w_found = 1'b1;
                end
            end
        end
    end

    assign w_grant    = (r_state == S_IDLE) && !i_tx_busy && (|i_tx_pend);
    assign w_wd_inc   = r_wd + 8'd1;
    assign w_expire   = i_tick_ms && (w_wd_inc == 8'(TO_MS));
    // A completion in the expiry cycle wins; the watchdog stays silent then.
    assign w_tmo_evt  = (r_state != S_IDLE) && !i_tx_done && w_expire;
    assign w_next_ptr = (o_sel == SW'(N - 1)) ? '0 : o_sel + SW'(1);

    // Completion is routed combinationally to the owner while a frame is open;
    // a stray tx_done in IDLE never reaches any requester.
    always_comb begin
        o_tx_done = '0;
        if ((r_state != S_IDLE) && i_tx_done) o_tx_done[o_sel] = 1'b1;
    end

    // WAIT_BUSY and WAIT_DONE react identically to tx_done and the watchdog,
    // which covers short frames whose tx_done arrives before busy is seen.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_wd      <= '0;
            o_send    <= 1'b0;
            o_tx_acpt <= '0;
            o_sel     <= '0;
            o_tmo     <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so every
            // read in this block sees the pre-edge value.
            o_send    <= 1'b0;
            o_tx_acpt <= '0;
            o_tmo     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        o_send    <= 1'b1;
                        o_tx_acpt <= N'(1) << w_win;
                        o_sel     <= w_win;
                        r_wd      <= '0;
                        r_state   <= S_WAIT_BUSY;
                    end
                end
                S_WAIT_BUSY, S_WAIT_DONE: begin
                    if (i_tx_done) begin
                        r_ptr   <= w_next_ptr;
                        r_state <= S_IDLE;
                    end else if (w_tmo_evt) begin
                        o_tmo   <= 1'b1;
                        r_ptr   <= w_next_ptr;
                        r_state <= S_IDLE;
                    end else begin
                        if (i_tick_ms) r_wd <= w_wd_inc;
                        if ((r_state == S_WAIT_BUSY) && i_tx_busy) r_state <= S_WAIT_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef QNIGMA_TX_SCHED_STATS_EN
    logic [15:0] r_grants [N];
    logic [15:0] r_tmo_cnt;

    // NOTE: this small counter array is reset explicitly because the counts
    // must read zero after rst; it is registers, not a RAM.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < N; i++) r_grants[i] <= '0;
            r_tmo_cnt <= '0;
        end else begin
            if (w_grant && (r_grants[w_win] != 16'hFFFF))
                r_grants[w_win] <= r_grants[w_win] + 16'd1;
            if (w_tmo_evt && (r_tmo_cnt != 16'hFFFF))
                r_tmo_cnt <= r_tmo_cnt + 16'd1;
        end
    end

    always_comb begin
        o_stat_grants = '0;
        for (int i = 0; i < N; i++) o_stat_grants[i*16 +: 16] = r_grants[i];
    end
    assign o_stat_tmo = r_tmo_cnt;
`else
    assign o_stat_grants = '0;
    assign o_stat_tmo    = '0;
`endif

endmodule
